// File: rtl/vid_timing_pkg.sv
// Shared timing defaults, controller state encoding and frame-size helpers
// for the synthetic video source.
package vid_timing_pkg;

  localparam int DEF_H_ACTIVE    = 800;
  localparam int DEF_H_FP        = 40;
  localparam int DEF_H_SYNC      = 128;
  localparam int DEF_H_BP        = 88;
  localparam int DEF_V_ACTIVE    = 600;
  localparam int DEF_V_FP        = 1;
  localparam int DEF_V_SYNC      = 4;
  localparam int DEF_V_BP        = 23;
  localparam int DEF_SYNC_POL    = 1;
  localparam int DEF_MOTION_STEP = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic int h_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int v_total(input int act, input int fp, input int sync, input int bp);
    return act + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_timing_core.sv
// Raster h/v counters with registered sync/de/count outputs and a frame-wrap
// strobe; counters sit at 0 whenever i_advance is low.
module video_timing_core
  import vid_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = DEF_SYNC_POL
) (
  input  logic        pixelclk,
  input  logic        reset_n,
  input  logic        i_advance,
  output logic [11:0] o_h,
  output logic [11:0] o_v,
  output logic        o_wrap,
  output logic        o_active,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [11:0] o_hcount,
  output logic [11:0] o_vcount
);

  localparam int H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic        POL      = 1'(SYNC_POL);

  logic [11:0] r_h, r_v;
  logic        r_hsync, r_vsync, r_de;
  logic [11:0] r_hcount, r_vcount;
  logic        w_h_last, w_v_last, w_hs_on, w_vs_on;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_hs_on  = (r_h >= HS_START) && (r_h < HS_END);
  assign w_vs_on  = (r_v >= VS_START) && (r_v < VS_END);

  always_ff @(posedge pixelclk) begin
    if (reset_n || !i_advance) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_h_last) begin
      r_h <= '0;
      r_v <= w_v_last ? 12'd0 : r_v + 12'd1;
    end else begin
      r_h <= r_h + 12'd1;
    end
  end

  // Output stage lags the counters by one cycle; idle forces reset levels.
  always_ff @(posedge pixelclk) begin
    if (reset_n || !i_advance) begin
      r_hsync  <= ~POL;
      r_vsync  <= ~POL;
      r_de     <= 1'b0;
      r_hcount <= '0;
      r_vcount <= '0;
    end else begin
      r_hsync  <= w_hs_on ? POL : ~POL;
      r_vsync  <= w_vs_on ? POL : ~POL;
      r_de     <= o_active;
      r_hcount <= r_h;
      r_vcount <= r_v;
    end
  end

  assign o_h      = r_h;
  assign o_v      = r_v;
  assign o_wrap   = i_advance && w_h_last && w_v_last;
  assign o_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign o_hsync  = r_hsync;
  assign o_vsync  = r_vsync;
  assign o_de     = r_de;
  assign o_hcount = r_hcount;
  assign o_vcount = r_vcount;

endmodule

// File: rtl/video_pattern_gen.sv
// Synthetic video source: solid object box on a background, frame-shadowed.
// Define PATTERN_MOTION_EN to make the box drift horizontally frame by frame.
//
// state | meaning
// IDLE  | counters at 0, outputs at reset levels, waiting for en
// RUN   | raster running, en high
// DRAIN | en dropped, finishing the current frame
module video_pattern_gen
  import vid_timing_pkg::*;
#(
`ifdef PATTERN_MOTION_EN
  parameter int MOTION_STEP = DEF_MOTION_STEP,
`endif
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int SYNC_POL = DEF_SYNC_POL
) (
  input  logic        pixelclk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [11:0] box_hl,
  input  logic [11:0] box_hr,
  input  logic [11:0] box_vl,
  input  logic [11:0] box_vr,
  input  logic [23:0] obj_rgb,
  input  logic [23:0] bg_rgb,
  output logic [23:0] o_rgb,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [11:0] hcount,
  output logic [11:0] vcount,
  output logic        frame_start,
  output logic        busy
);

  state_t      r_state, w_state_nxt;
  logic        w_running, w_start, w_load, w_wrap, w_active, w_inside;
  logic [11:0] w_h, w_v, w_hl_eff, w_hr_eff;
  logic [11:0] r_hl, r_hr, r_vl, r_vr;
  logic [23:0] r_obj, r_bg, r_rgb;
  logic        r_fs, r_busy;

  assign w_running = (r_state != ST_IDLE);
  assign w_start   = (r_state == ST_IDLE) && en;
  assign w_load    = w_start || w_wrap;

  video_timing_core #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .SYNC_POL(SYNC_POL)
  ) u_core (
    .pixelclk (pixelclk),
    .reset_n  (reset_n),
    .i_advance(w_running),
    .o_h      (w_h),
    .o_v      (w_v),
    .o_wrap   (w_wrap),
    .o_active (w_active),
    .o_hsync  (o_hsync),
    .o_vsync  (o_vsync),
    .o_de     (o_de),
    .o_hcount (hcount),
    .o_vcount (vcount)
  );

  always_ff @(posedge pixelclk) begin
    if (reset_n) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  // A frame is only ever abandoned at its wrap, so en glitches cannot shorten one.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (en) w_state_nxt = ST_RUN;
      ST_RUN:   if (!en) w_state_nxt = w_wrap ? ST_IDLE : ST_DRAIN;
      ST_DRAIN: begin
        if (en)          w_state_nxt = ST_RUN;
        else if (w_wrap) w_state_nxt = ST_IDLE;
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixelclk) begin
    if (reset_n) begin
      r_hl  <= '0;
      r_hr  <= '0;
      r_vl  <= '0;
      r_vr  <= '0;
      r_obj <= '0;
      r_bg  <= '0;
    end else if (w_load) begin
      r_hl  <= box_hl;
      r_hr  <= box_hr;
      r_vl  <= box_vl;
      r_vr  <= box_vr;
      r_obj <= obj_rgb;
      r_bg  <= bg_rgb;
    end
  end

`ifdef PATTERN_MOTION_EN
  localparam logic signed [13:0] STEP_14 = 14'(MOTION_STEP);
  localparam logic signed [13:0] XMAX_14 = 14'(H_ACTIVE - 1);
  localparam logic signed [11:0] STEP_12 = 12'(MOTION_STEP);

  logic signed [11:0] r_offset, w_offset_nxt;
  logic               r_dir_neg, w_dir_neg_nxt;
  logic signed [13:0] w_left_s, w_right_s;

  assign w_left_s  = $signed({2'b00, r_hl}) + 14'(r_offset);
  assign w_right_s = $signed({2'b00, r_hr}) + 14'(r_offset);

  // Bounce: flip direction when the next step would leave the active width.
  always_comb begin
    w_dir_neg_nxt = r_dir_neg;
    w_offset_nxt  = r_offset;
    if (!r_dir_neg) begin
      if (w_right_s + STEP_14 > XMAX_14) begin
        w_dir_neg_nxt = 1'b1;
        w_offset_nxt  = r_offset - STEP_12;
      end else begin
        w_offset_nxt  = r_offset + STEP_12;
      end
    end else begin
      if (w_left_s - STEP_14 < 14'sd0) begin
        w_dir_neg_nxt = 1'b0;
        w_offset_nxt  = r_offset + STEP_12;
      end else begin
        w_offset_nxt  = r_offset - STEP_12;
      end
    end
  end

  always_ff @(posedge pixelclk) begin
    if (reset_n || w_start) begin
      r_offset  <= '0;
      r_dir_neg <= 1'b0;
    end else if (w_wrap) begin
      r_offset  <= w_offset_nxt;
      r_dir_neg <= w_dir_neg_nxt;
    end
  end

  assign w_hl_eff = r_hl + $unsigned(r_offset);
  assign w_hr_eff = r_hr + $unsigned(r_offset);
`else
  assign w_hl_eff = r_hl;
  assign w_hr_eff = r_hr;
`endif

  // An inverted box (left > right or top > bottom) never matches: empty box.
  assign w_inside = (w_h >= w_hl_eff) && (w_h <= w_hr_eff) &&
                    (w_v >= r_vl) && (w_v <= r_vr);

  always_ff @(posedge pixelclk) begin
    if (reset_n || !w_running) begin
      r_rgb  <= '0;
      r_fs   <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_rgb  <= w_active ? (w_inside ? r_obj : r_bg) : 24'd0;
      r_fs   <= (w_h == 12'd0) && (w_v == 12'd0);
      r_busy <= 1'b1;
    end
  end

  assign o_rgb       = r_rgb;
  assign frame_start = r_fs;
  assign busy        = r_busy;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen on a reduced 24x12 raster.
module tb_video_pattern_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam logic [23:0] RED   = 24'hFF0000;
  localparam logic [23:0] GREEN = 24'h00FF00;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [11:0] hl, hr, vl, vr;
  logic [23:0] obj, bg;
  logic [23:0] o_rgb;
  logic        o_hsync, o_vsync, o_de, frame_start, busy;
  logic [11:0] hcount, vcount;

  always #5 clk = ~clk;

  video_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1)
  ) dut (
    .pixelclk(clk), .reset_n(rst), .en(en),
    .box_hl(hl), .box_hr(hr), .box_vl(vl), .box_vr(vr),
    .obj_rgb(obj), .bg_rgb(bg),
    .o_rgb(o_rgb), .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de),
    .hcount(hcount), .vcount(vcount), .frame_start(frame_start), .busy(busy)
  );

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Model: a frame is a linear run of FR pixel slots; en only matters at the
  // end of a frame (or while idle). Box and colours latch at frame start.
  bit          m_active = 1'b0, e_valid = 1'b0;
  int          m_pos = 0;
  int          s_hl, s_hr, s_vl, s_vr;
  logic [23:0] s_obj, s_bg;
  logic [52:0] e_vec;

  function automatic logic [52:0] pixel_vec(input int pos);
    int h, v;
    logic de, hs, vs, ins;
    logic [23:0] rgb;
    h   = pos % HT;
    v   = pos / HT;
    de  = (h < HA) && (v < VA);
    hs  = (h >= HA + HF) && (h < HA + HF + HS);
    vs  = (v >= VA + VF) && (v < VA + VF + VS);
    ins = (h >= s_hl) && (h <= s_hr) && (v >= s_vl) && (v <= s_vr);
    rgb = de ? (ins ? s_obj : s_bg) : 24'd0;
    return {rgb, hs, vs, de, 12'(h), 12'(v), (pos == 0), 1'b1};
  endfunction

  task automatic load_shadow();
    s_hl = int'(hl); s_hr = int'(hr); s_vl = int'(vl); s_vr = int'(vr);
    s_obj = obj; s_bg = bg;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      e_vec = '0;
      m_active = 1'b0;
      m_pos = 0;
      s_hl = 0; s_hr = 0; s_vl = 0; s_vr = 0; s_obj = '0; s_bg = '0;
    end else if (!m_active) begin
      e_vec = '0;
      if (en) begin
        m_active = 1'b1;
        m_pos = 0;
        load_shadow();
      end
    end else begin
      e_vec = pixel_vec(m_pos);
      if (m_pos == FR - 1) begin
        m_pos = 0;
        load_shadow();
        if (!en) m_active = 1'b0;
      end else begin
        m_pos++;
      end
    end
    e_valid = 1'b1;
  end

  // Per-cycle compare plus frame bookkeeping used by the directed checks.
  int cyc = 0, last_fs = -1, fs_period = 0;
  int cur_obj = 0, cur_bg = 0, fr_obj = -1, fr_bg = -1;
  int last_bh = -1, last_bv = -1;
  logic [52:0] a_vec;

  always @(negedge clk) begin
    a_vec = {o_rgb, o_hsync, o_vsync, o_de, hcount, vcount, frame_start, busy};
    if (e_valid) begin
      n_chk++;
      if (a_vec == e_vec) n_pass++;
      else $display("FAIL stream t=%0t got %h expected %h", $time, a_vec, e_vec);
    end
    cyc++;
    if (frame_start) begin
      if (last_fs >= 0) fs_period = cyc - last_fs;
      last_fs = cyc;
      fr_obj = cur_obj; fr_bg = cur_bg;
      cur_obj = 0; cur_bg = 0;
    end
    if (o_de && o_rgb == RED)   cur_obj++;
    if (o_de && o_rgb == GREEN) cur_bg++;
    if (busy) begin
      last_bh = int'(hcount);
      last_bv = int'(vcount);
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_fs();
    int n = 0;
    do begin tick(); n++; end while (!frame_start && n < FR + 10);
    if (!frame_start) check("wait_fs_timeout", 0, 1);
  endtask

  task automatic wait_hv(input int h, input int v);
    int n = 0;
    while (!(int'(hcount) == h && int'(vcount) == v) && n < 2 * FR) begin tick(); n++; end
    if (n >= 2 * FR) check("wait_hv_timeout", 0, 1);
  endtask

  task automatic measure_first_fs(input string name);
    int n = 0;
    do begin tick(); n++; end while (!frame_start && n < 50);
    check(name, n, 2);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0;
    hl = 12'd4; hr = 12'd7; vl = 12'd2; vr = 12'd3;
    obj = RED; bg = GREEN;
    repeat (3) tick();
    check("reset_hsync", o_hsync, 0);
    check("reset_busy", busy, 0);

    rst = 1'b0; en = 1'b1;
    measure_first_fs("first_fs_delay");
    wait_fs();
    wait_fs();
    check("box_obj_pixels", fr_obj, 8);
    check("box_bg_pixels", fr_bg, 120);
    check("fs_period", fs_period, 288);

    // Box made empty mid-frame: current frame keeps the old box.
    wait_hv(5, 4);
    hl = 12'd9; hr = 12'd3;
    wait_fs();
    check("shadow_frame_obj", fr_obj, 8);
    wait_fs();
    check("empty_box_obj", fr_obj, 0);
    check("empty_box_bg", fr_bg, 128);
    hl = 12'd4; hr = 12'd7;
    wait_fs();
    wait_fs();
    check("restored_box_obj", fr_obj, 8);

    // en glitch inside one frame.
    wait_hv(0, 2);
    en = 1'b0;
    repeat (5) tick();
    en = 1'b1;
    wait_fs();
    check("glitch_fs_period", fs_period, 288);

    // Drain from line 3.
    wait_hv(0, 3);
    en = 1'b0;
    begin
      int n = 0;
      while (busy && n < 2 * FR) begin tick(); n++; end
      check("drain_done", busy, 0);
    end
    check("drain_last_h", last_bh, 23);
    check("drain_last_v", last_bv, 11);
    repeat (10) tick();
    check("idle_de", o_de, 0);
    check("idle_vsync", o_vsync, 0);

    // Reset mid-frame at line 5.
    en = 1'b1;
    wait_hv(0, 5);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check("midrst_hcount", int'(hcount), 0);
    check("midrst_vcount", int'(vcount), 0);
    check("midrst_rgb", int'(o_rgb), 0);
    check("midrst_busy", busy, 0);
    check("midrst_hsync", o_hsync, 0);
    rst = 1'b0;
    measure_first_fs("post_reset_fs_delay");
    wait_fs();
    check("post_reset_obj", fr_obj, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/video_pattern_gen.md
Name: video_pattern_gen

Overview:
- Synthetic video source driving the same rgb/hsync/vsync/de/hcount/vcount stream that the fruit-recognition ISP chain consumes.
- Renders a solid "object" rectangle (object colour) on a background colour at a host-supplied bounding box.
- Lets the capture, binarisation and projection path be checked in-system, with a known expected box, without a camera.
- Sits in place of the camera/HDMI input in front of the judge pipeline.

Parameters:
- H_ACTIVE, 800, active pixels per line
- H_FP, 40, horizontal front porch
- H_SYNC, 128, hsync width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 600, active lines
- V_FP, 1, vertical front porch
- V_SYNC, 4, vsync width
- V_BP, 23, vertical back porch
- SYNC_POL, 1, active level of o_hsync/o_vsync
- MOTION_STEP, 2, pixels per frame of box drift (optional feature only)

Ports:
- pixelclk  in  1  pixel clock
- reset_n  in  1  synchronous reset, active-high; the name is kept for codebase consistency
- en  in  1  run request
- box_hl  in  12  object left column, inclusive
- box_hr  in  12  object right column, inclusive
- box_vl  in  12  object top line, inclusive
- box_vr  in  12  object bottom line, inclusive
- obj_rgb  in  24  object colour
- bg_rgb  in  24  background colour
- o_rgb  out  24  pixel data
- o_hsync  out  1  horizontal sync
- o_vsync  out  1  vertical sync
- o_de  out  1  data enable
- hcount  out  12  column of the current output pixel
- vcount  out  12  line of the current output pixel
- frame_start  out  1  one-cycle pulse on the first pixel of each frame
- busy  out  1  high while in RUN or DRAIN

Behaviour:
- Derived constants: H_TOTAL = sum of the four H parameters (1056 by default); V_TOTAL = sum of the four V parameters (628 by default).
- Internal counters: h counts 0..H_TOTAL-1 and wraps to 0 while incrementing v; v counts 0..V_TOTAL-1 and wraps to 0.
- All outputs are registered. Outputs in cycle n+1 reflect counter values (h, v) from cycle n.
  - hcount = h, vcount = v.
  - o_de = (h < H_ACTIVE) and (v < V_ACTIVE).
  - o_hsync = SYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else inverse.
  - o_vsync: same rule on v with the V parameters; it is line-aligned and changes at h = 0.
  - o_rgb = obj_rgb when o_de and the pixel lies inside the box; bg_rgb when o_de and outside; 0 when not o_de.
- Box membership: inside when box_hl <= h <= box_hr and box_vl <= v <= box_vr, 12-bit unsigned compare.
  - If box_hl > box_hr or box_vl > box_vr, the box is empty and every active pixel is bg_rgb.
- Shadowing:
  - box_* and both colours are sampled into shadow registers on the IDLE->RUN transition and on every frame wrap (h = H_TOTAL-1 and v = V_TOTAL-1).
  - Changes mid-frame never tear a frame.
- frame_start is high on the output cycle where hcount = 0 and vcount = 0 while busy.
- FSM:
  - IDLE: counters held at 0, outputs at reset values. Goes to RUN when en = 1.
  - RUN: counters advance every cycle. If en = 0, goes to DRAIN.
  - DRAIN: the current frame completes. At frame wrap it goes to IDLE. If en returns to 1 before the wrap, it goes back to RUN with no timing break.
  - en toggling inside one frame never shortens or restarts a frame.
- Reset: takes priority over all other events, at any point including mid-frame. On the next edge: state IDLE, o_rgb = 0, o_de = 0, o_hsync = o_vsync = ~SYNC_POL, hcount = vcount = 0, frame_start = 0, busy = 0, shadow registers = 0.

Optional Feature:
- Macro: PATTERN_MOTION_EN.
- Defined:
  - A signed 12-bit horizontal offset is added to the shadowed box_hl and box_hr.
  - At each frame wrap the offset advances by +/-MOTION_STEP.
  - Direction reverses when the moved right edge + MOTION_STEP would exceed H_ACTIVE-1, or the moved left edge - MOTION_STEP would go below 0.
  - Offset resets to 0 on reset and on IDLE->RUN.
- Undefined: no offset logic; the box is static.

Decomposition:
- Package vid_timing_pkg holds:
  - the default timing constants;
  - the FSM state encoding (IDLE/RUN/DRAIN);
  - the H_TOTAL/V_TOTAL derivation functions.
- One sub-module, video_timing_core: h/v counters, sync/de generation, frame-wrap strobe.
- The top level adds the FSM, shadow registers, box compare and colour mux.

Test Plan:
- Timing: reduced parameters H 16/2/3/3 (H_TOTAL 24), V 8/1/2/1 (V_TOTAL 12), en = 1 -> o_de high for 16 cycles per line on lines 0..7 only; o_hsync high at hcount 18..20; o_vsync high on lines 9..10; frame_start every 288 cycles.
- Box colour: box 4..7 x 2..3, obj 0xFF0000, bg 0x00FF00 -> exactly 8 red pixels per frame, at columns 4..7 of lines 2 and 3; all other active pixels green; blanking pixels 0.
- Empty box and shadowing: box_hl = 9, box_hr = 3 -> zero obj pixels. Box changed at hcount 5, vcount 4 -> the current frame is unchanged and the new box appears from the next frame.
- Drain: en dropped at line 3 -> the frame runs to vcount 11, hcount 23, then busy = 0 and the outputs idle. en pulsed low then high within one frame -> frame_start period stays 288.
- Reset mid-frame at line 5 -> next cycle all outputs are at reset values. After release with en = 1 -> the first frame_start occurs 1 cycle after the reset-free edge that enters RUN.
- With PATTERN_MOTION_EN: box 0..3 -> box left edge at 0, 2, 4, ... over successive frames until right edge reaches 15, then the direction reverses.
